// File: rtl/wb_arb_pkg.sv
// Shared types, bus widths and the round-robin search helper for the Wishbone RAM arbiter.
package wb_arb_pkg;

   typedef enum logic {IDLE, GRANTED} arb_state_t;

   localparam int unsigned WB_ADR_W    = 32;
   localparam int unsigned WB_DAT_W    = 32;
   localparam int unsigned WB_SEL_W    = 4;
   localparam int unsigned MAX_MASTERS = 8;

   // First requester strictly after `last`, wrapping modulo n; all zero if nobody requests.
   function automatic logic [MAX_MASTERS-1:0] rr_pick(input logic [MAX_MASTERS-1:0] req,
                                                      input int unsigned           last,
                                                      input int unsigned           n);
      logic [MAX_MASTERS-1:0] gnt;
      logic                   found;
      logic [2:0]             idx;
      gnt   = '0;
      found = 1'b0;
      for (int unsigned off = 1; off <= MAX_MASTERS; off++) begin
         idx = 3'((last + off) % n);
         if (off <= n && !found && req[idx]) begin
            gnt[idx] = 1'b1;
            found    = 1'b1;
         end
      end
      return gnt;
   endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin search: one-hot grant and its index for the next requester.
module rr_priority_picker
   import wb_arb_pkg::*;
#(
   parameter int unsigned N_MASTERS = 3
) (
   input  logic [N_MASTERS-1:0]         req_i,
   input  logic [$clog2(N_MASTERS)-1:0] last_i,
   output logic [N_MASTERS-1:0]         grant_o,
   output logic [$clog2(N_MASTERS)-1:0] idx_o,
   output logic                         valid_o
);

   localparam int unsigned IdxW = $clog2(N_MASTERS);

   logic [MAX_MASTERS-1:0] req_ext;
   logic [MAX_MASTERS-1:0] pick_all;
   logic                   unused_pick;

   always_comb begin
      req_ext                = '0;
      req_ext[N_MASTERS-1:0] = req_i;
      pick_all               = rr_pick(req_ext, 32'(last_i), N_MASTERS);
      grant_o                = pick_all[N_MASTERS-1:0];
      valid_o                = |req_i;
      idx_o                  = '0;
      for (int unsigned i = 0; i < N_MASTERS; i++) begin
         if (pick_all[i]) begin
            idx_o = IdxW'(i);
         end
      end
   end

   assign unused_pick = ^pick_all;

endmodule

// File: rtl/wb_ram_arbiter.sv
// Round-robin Wishbone arbiter sharing one RAM slave port between N masters.
// Optional watchdog enabled by defining WB_ARB_TIMEOUT_EN.
module wb_ram_arbiter
   import wb_arb_pkg::*;
#(
   parameter int unsigned N_MASTERS      = 3,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic                          p_clk,
   input  logic                          p_reset,
   input  logic [N_MASTERS-1:0]          m_CYC_I,
   input  logic [N_MASTERS-1:0]          m_STB_I,
   input  logic [N_MASTERS-1:0]          m_WE_I,
   input  logic [N_MASTERS-1:0]          m_LOCK_I,
   input  logic [WB_ADR_W*N_MASTERS-1:0] m_ADR_I,
   input  logic [WB_DAT_W*N_MASTERS-1:0] m_DAT_I,
   input  logic [WB_SEL_W*N_MASTERS-1:0] m_SEL_I,
   output logic [WB_DAT_W-1:0]           m_DAT_O,
   output logic [N_MASTERS-1:0]          m_ACK_O,
   output logic [N_MASTERS-1:0]          m_ERR_O,
   output logic [N_MASTERS-1:0]          m_RTY_O,
   output logic                          s_CYC_O,
   output logic                          s_STB_O,
   output logic                          s_WE_O,
   output logic                          s_LOCK_O,
   output logic [WB_ADR_W-1:0]           s_ADR_O,
   output logic [WB_DAT_W-1:0]           s_DAT_O,
   output logic [WB_SEL_W-1:0]           s_SEL_O,
   input  logic [WB_DAT_W-1:0]           s_DAT_I,
   input  logic                          s_ACK_I,
   input  logic                          s_ERR_I,
   input  logic                          s_RTY_I,
   output logic [N_MASTERS-1:0]          grant_o,
   output logic                          timeout_o
);

   localparam int unsigned IdxW = $clog2(N_MASTERS);

   arb_state_t           state_q, state_d;
   logic [N_MASTERS-1:0] grant_q, grant_d;
   logic [IdxW-1:0]      last_q, last_d;
   logic [N_MASTERS-1:0] pick_gnt;
   logic [IdxW-1:0]      pick_idx;
   logic                 pick_vld;
   logic                 tmo_fire;

   rr_priority_picker #(
      .N_MASTERS(N_MASTERS)
   ) u_picker (
      .req_i  (m_CYC_I),
      .last_i (last_q),
      .grant_o(pick_gnt),
      .idx_o  (pick_idx),
      .valid_o(pick_vld)
   );

`ifdef WB_ARB_TIMEOUT_EN
   logic [15:0] cnt_q, cnt_d;
   logic        timeout_q, timeout_d;

   assign tmo_fire = (state_q == GRANTED) && (cnt_q == 16'(TIMEOUT_CYCLES));

   always_comb begin
      cnt_d     = cnt_q;
      timeout_d = timeout_q | tmo_fire;
      if (state_q == IDLE || s_ACK_I || s_ERR_I || s_RTY_I) begin
         cnt_d = '0;
      end else if (s_STB_O) begin
         cnt_d = cnt_q + 16'd1;
      end
   end

   always_ff @(posedge p_clk) begin
      if (p_reset) begin
         cnt_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
      end
   end

   assign timeout_o = timeout_q;
`else
   logic unused_tmo_cfg;
   assign unused_tmo_cfg = ^TIMEOUT_CYCLES;
   assign tmo_fire       = 1'b0;
   assign timeout_o      = 1'b0;
`endif

   // last_q doubles as the granted index while GRANTED.
   always_comb begin
      s_CYC_O  = 1'b0;
      s_STB_O  = 1'b0;
      s_WE_O   = 1'b0;
      s_LOCK_O = 1'b0;
      s_ADR_O  = '0;
      s_DAT_O  = '0;
      s_SEL_O  = '1;
      m_ACK_O  = '0;
      m_ERR_O  = '0;
      m_RTY_O  = '0;
      m_DAT_O  = s_DAT_I;
      if (state_q == GRANTED) begin
         s_CYC_O  = m_CYC_I[last_q] & ~tmo_fire;
         s_STB_O  = m_STB_I[last_q] & ~tmo_fire;
         s_WE_O   = m_WE_I[last_q];
         s_LOCK_O = m_LOCK_I[last_q];
         s_ADR_O  = m_ADR_I[WB_ADR_W*last_q +: WB_ADR_W];
         s_DAT_O  = m_DAT_I[WB_DAT_W*last_q +: WB_DAT_W];
         s_SEL_O  = m_SEL_I[WB_SEL_W*last_q +: WB_SEL_W];
         m_ACK_O  = grant_q & {N_MASTERS{s_ACK_I}};
         m_ERR_O  = grant_q & {N_MASTERS{s_ERR_I | tmo_fire}};
         m_RTY_O  = grant_q & {N_MASTERS{s_RTY_I}};
      end
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      unique case (state_q)
         IDLE: begin
            if (pick_vld) begin
               state_d = GRANTED;
               grant_d = pick_gnt;
               last_d  = pick_idx;
            end
         end
         GRANTED: begin
            if (tmo_fire || (!m_CYC_I[last_q] && !m_LOCK_I[last_q])) begin
               state_d = IDLE;
               grant_d = '0;
            end
         end
      endcase
   end

   always_ff @(posedge p_clk) begin
      if (p_reset) begin
         state_q <= IDLE;
         grant_q <= '0;
         last_q  <= IdxW'(N_MASTERS - 1);
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
      end
   end

   assign grant_o = grant_q;

endmodule

// File: tb/tb_wb_ram_arbiter.sv
// Directed bench for wb_ram_arbiter with three masters; watchdog steps run when
// WB_ARB_TIMEOUT_EN is defined.
module tb_wb_ram_arbiter;

   logic         p_clk = 1'b0;
   logic         p_reset;
   logic [2:0]   cyc, stb, we, lock;
   logic [95:0]  adr, dat;
   logic [11:0]  sel;
   logic [31:0]  m_DAT_O;
   logic [2:0]   m_ACK_O, m_ERR_O, m_RTY_O;
   logic         s_CYC_O, s_STB_O, s_WE_O, s_LOCK_O;
   logic [31:0]  s_ADR_O, s_DAT_O;
   logic [3:0]   s_SEL_O;
   logic [31:0]  s_DAT_I;
   logic         s_ACK_I, s_ERR_I, s_RTY_I;
   logic [2:0]   grant_o;
   logic         timeout_o;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 p_clk = ~p_clk;

   wb_ram_arbiter #(
      .N_MASTERS     (3),
      .TIMEOUT_CYCLES(16)
   ) dut (
      .p_clk    (p_clk),
      .p_reset  (p_reset),
      .m_CYC_I  (cyc),
      .m_STB_I  (stb),
      .m_WE_I   (we),
      .m_LOCK_I (lock),
      .m_ADR_I  (adr),
      .m_DAT_I  (dat),
      .m_SEL_I  (sel),
      .m_DAT_O  (m_DAT_O),
      .m_ACK_O  (m_ACK_O),
      .m_ERR_O  (m_ERR_O),
      .m_RTY_O  (m_RTY_O),
      .s_CYC_O  (s_CYC_O),
      .s_STB_O  (s_STB_O),
      .s_WE_O   (s_WE_O),
      .s_LOCK_O (s_LOCK_O),
      .s_ADR_O  (s_ADR_O),
      .s_DAT_O  (s_DAT_O),
      .s_SEL_O  (s_SEL_O),
      .s_DAT_I  (s_DAT_I),
      .s_ACK_I  (s_ACK_I),
      .s_ERR_I  (s_ERR_I),
      .s_RTY_I  (s_RTY_I),
      .grant_o  (grant_o),
      .timeout_o(timeout_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge p_clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      p_reset = 1'b1;
      cyc = '0; stb = '0; we = '0; lock = '0;
      adr = '0; dat = '0; sel = '0;
      s_DAT_I = 32'hCAFEF00D;
      s_ACK_I = 1'b0; s_ERR_I = 1'b0; s_RTY_I = 1'b0;
      step();
      step();
      p_reset = 1'b0;

      // Reset state, and a slave ACK with no grant is dropped.
      chk("rst_grant", 32'(grant_o), 0);
      chk("rst_cyc", 32'(s_CYC_O), 0);
      chk("rst_sel", 32'(s_SEL_O), 32'hF);
      chk("rst_adr", s_ADR_O, 0);
      chk("rst_timeout", 32'(timeout_o), 0);
      s_ACK_I = 1'b1;
      #1;
      chk("idle_ack_dropped", 32'(m_ACK_O), 0);
      s_ACK_I = 1'b0;

      // Single master 0 transfer.
      cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b1;
      adr[31:0] = 32'h41000000; dat[31:0] = 32'h11111111; sel[3:0] = 4'h3;
      adr[63:32] = 32'h52000000;
      #1;
      chk("arb_latency", 32'(grant_o), 0);
      step();
      chk("m0_grant", 32'(grant_o), 1);
      chk("m0_adr", s_ADR_O, 32'h41000000);
      chk("m0_dat", s_DAT_O, 32'h11111111);
      chk("m0_sel", 32'(s_SEL_O), 32'h3);
      chk("m0_we_cyc", {30'd0, s_WE_O, s_CYC_O}, 3);
      chk("rd_data", m_DAT_O, 32'hCAFEF00D);
      s_ACK_I = 1'b1;
      #1;
      chk("m0_ack_route", 32'(m_ACK_O), 1);
      cyc[0] = 1'b0; stb[0] = 1'b0; s_ACK_I = 1'b0;
      step();
      chk("m0_release", 32'(grant_o), 0);

      // All three request; each releases after one ACK. last_grant=0 so order is 1,2,0.
      cyc = 3'b111; stb = 3'b111;
      step();
      chk("rr_first", 32'(grant_o), 32'b010);
      cyc[1] = 1'b0;
      step();
      chk("rr_gap1", 32'(grant_o), 0);
      cyc[1] = 1'b1;
      step();
      chk("rr_second", 32'(grant_o), 32'b100);
      cyc[2] = 1'b0;
      step();
      chk("rr_gap2", 32'(grant_o), 0);
      cyc[2] = 1'b1;
      step();
      chk("rr_third", 32'(grant_o), 32'b001);
      cyc = '0; stb = '0;
      step();
      chk("rr_end_idle", 32'(grant_o), 0);

      // Master 0 eight-beat burst while master 1 waits.
      cyc[0] = 1'b1; stb[0] = 1'b1;
      step();
      chk("burst_grant0", 32'(grant_o), 1);
      cyc[1] = 1'b1; stb[1] = 1'b1;
      for (int b = 0; b < 8; b++) begin
         s_ACK_I = 1'b1;
         #1;
         chk("burst_hold", 32'(grant_o), 1);
         chk("burst_ack", 32'(m_ACK_O), 1);
         chk("burst_adr", s_ADR_O, 32'h41000000);
         step();
      end
      s_ACK_I = 1'b0;
      cyc[0] = 1'b0; stb[0] = 1'b0;
      #1;
      chk("burst_cyc_fall", 32'(s_CYC_O), 0);
      step();
      chk("burst_gap", 32'(grant_o), 0);
      step();
      chk("burst_next", 32'(grant_o), 32'b010);
      chk("burst_next_adr", s_ADR_O, 32'h52000000);
      cyc[1] = 1'b0; stb[1] = 1'b0;
      step();
      chk("burst_end_idle", 32'(grant_o), 0);

      // LOCK from master 2 keeps the grant while its CYC drops; master 0 waits.
      cyc[2] = 1'b1; stb[2] = 1'b1; lock[2] = 1'b1; cyc[0] = 1'b1; stb[0] = 1'b1;
      step();
      chk("lock_grant", 32'(grant_o), 32'b100);
      cyc[2] = 1'b0; stb[2] = 1'b0;
      for (int c = 0; c < 3; c++) begin
         step();
         chk("lock_hold", 32'(grant_o), 32'b100);
         chk("lock_scyc", {30'd0, s_LOCK_O, s_CYC_O}, 2);
      end
      cyc[2] = 1'b1; stb[2] = 1'b1;
      step();
      chk("lock_reassert", 32'(grant_o), 32'b100);
      cyc[2] = 1'b0; stb[2] = 1'b0; lock[2] = 1'b0;
      step();
      chk("lock_gap", 32'(grant_o), 0);
      step();
      chk("lock_after", 32'(grant_o), 32'b001);
      cyc = '0; stb = '0;
      step();

      // Reset mid-burst of master 1; master 0 wins first afterwards.
      cyc[1] = 1'b1; stb[1] = 1'b1;
      step();
      chk("rst_mid_grant", 32'(grant_o), 32'b010);
      s_ACK_I = 1'b1;
      step();
      s_ACK_I = 1'b0;
      cyc[0] = 1'b1; stb[0] = 1'b1;
      p_reset = 1'b1;
      step();
      p_reset = 1'b0;
      chk("rst_mid_grant0", 32'(grant_o), 0);
      chk("rst_mid_cyc", 32'(s_CYC_O), 0);
      step();
      chk("rst_mid_first", 32'(grant_o), 32'b001);
      cyc = '0; stb = '0;
      step();
      chk("rst_mid_idle", 32'(grant_o), 0);

`ifdef WB_ARB_TIMEOUT_EN
      // Slave never answers; watchdog fires after 16 strobed cycles.
      cyc[2] = 1'b1; stb[2] = 1'b1;
      step();
      chk("tmo_grant", 32'(grant_o), 32'b100);
      for (int t = 0; t < 16; t++) begin
         chk("tmo_no_err", 32'(m_ERR_O), 0);
         step();
      end
      chk("tmo_err_pulse", 32'(m_ERR_O), 32'b100);
      chk("tmo_force_low", {30'd0, s_STB_O, s_CYC_O}, 0);
      step();
      chk("tmo_idle", 32'(grant_o), 0);
      chk("tmo_flag", 32'(timeout_o), 1);
      chk("tmo_err_done", 32'(m_ERR_O), 0);
      cyc = '0; stb = '0;
      step();
      chk("tmo_sticky", 32'(timeout_o), 1);
      p_reset = 1'b1;
      step();
      p_reset = 1'b0;
      chk("tmo_reset_clr", 32'(timeout_o), 0);
`else
      chk("tmo_tied_low", 32'(timeout_o), 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/wb_ram_arbiter.md
Name: wb_ram_arbiter

Overview:
- Round-robin Wishbone arbiter that lets N masters share the single RAM slave port: video_in block writes, video_out reads and the CPU data path.
- Grant is held for a whole bus cycle (CYC) and across LOCK'd sequences, so video_in block bursts are never interleaved.
- Sits between the masters' WB interfaces and the RAM controller slave port.
- Single clock domain (100 MHz bus clock).

Parameters:
- N_MASTERS, 3, number of requesting masters (2..8).
- TIMEOUT_CYCLES, 1024, watchdog limit in cycles without ACK/ERR/RTY (used only with the optional feature).

Ports:
- p_clk  in  1  bus clock.
- p_reset  in  1  synchronous, active-high reset.
- m_CYC_I  in  N_MASTERS  per-master CYC.
- m_STB_I  in  N_MASTERS  per-master STB.
- m_WE_I  in  N_MASTERS  per-master WE.
- m_LOCK_I  in  N_MASTERS  per-master LOCK.
- m_ADR_I  in  32*N_MASTERS  packed addresses; master i at [32i+31:32i].
- m_DAT_I  in  32*N_MASTERS  packed write data.
- m_SEL_I  in  4*N_MASTERS  packed byte selects.
- m_DAT_O  out  32  read data, broadcast to all masters.
- m_ACK_O, m_ERR_O, m_RTY_O  out  N_MASTERS  each; routed to the granted master only.
- s_CYC_O, s_STB_O, s_WE_O, s_LOCK_O  out  1 each  to RAM slave.
- s_ADR_O  out  32  to RAM slave.
- s_DAT_O  out  32  to RAM slave.
- s_SEL_O  out  4  to RAM slave.
- s_DAT_I  in  32  from RAM slave.
- s_ACK_I, s_ERR_I, s_RTY_I  in  1 each  from RAM slave.
- grant_o  out  N_MASTERS  one-hot current grant; all zero when idle.
- timeout_o  out  1  sticky watchdog flag.

Behaviour:
- Reset (synchronous, applied at the next edge; also aborts any transfer in progress):
  - state=IDLE, grant_o=0, last_grant=N_MASTERS-1 (master 0 wins first), timeout_o=0.
  - All s_* control outputs 0; s_ADR_O/s_DAT_O=0; s_SEL_O=4'hF.
  - All m_ACK_O/m_ERR_O/m_RTY_O=0.
- States: IDLE, GRANTED.
- IDLE:
  - If any m_CYC_I is high, pick the first requester searching (last_grant+1) mod N upward with wrap-around.
  - Register that choice into grant_o and last_grant; go to GRANTED.
  - Arbitration latency is 1 cycle: CYC at edge k gives grant visible after edge k+1.
  - With no requests, stay in IDLE with outputs at reset values.
- GRANTED:
  - s_CYC/STB/WE/LOCK/ADR/DAT/SEL are combinational copies of the granted master's signals.
  - s_ACK/ERR/RTY are forwarded combinationally to the granted master's bit only; all other bits are 0.
  - m_DAT_O = s_DAT_I always.
- Release: when the granted master has m_CYC_I=0 and m_LOCK_I=0, go to IDLE at the next edge.
  - s_CYC_O falls with the master's CYC, because it is combinational.
  - At least one IDLE cycle always separates two grants.
- LOCK: while the granted master holds m_LOCK_I=1, the grant is kept even if its CYC drops between cycles. Other requesters wait.
- Fairness: after master i releases, any other waiting master is served before i is served again.
- Simultaneous requests and release: a release and new requests in the same cycle give IDLE for one cycle, then arbitration from the updated last_grant.
- A master dropping CYC while still in IDLE, before grant, is simply not selected; nothing is issued.
- Slave signals with no grant: ACK/ERR/RTY arriving in IDLE are dropped, not forwarded.

Optional Feature:
- Macro: WB_ARB_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on grant and on every s_ACK_I/s_ERR_I/s_RTY_I, and increments each GRANTED cycle with s_STB_O=1.
  - When it reaches TIMEOUT_CYCLES: pulse m_ERR_O for the granted master for 1 cycle, force s_CYC_O/s_STB_O low that cycle, go to IDLE, set timeout_o=1.
  - timeout_o clears only on reset.
- Undefined: no counter is built; timeout_o is tied to 0.

Decomposition:
- Package wb_arb_pkg holds:
  - typedef arb_state_t {IDLE, GRANTED};
  - constants WB_ADR_W=32, WB_DAT_W=32, WB_SEL_W=4;
  - function rr_pick(req, last) returning a one-hot grant.
- One natural sub-module: rr_priority_picker (combinational round-robin search, parameterised by N_MASTERS). The top holds the FSM, muxes and watchdog.

Test Plan:
- Reset then master 0 only: CYC/STB/WE=1, ADR=0x41000000. Expect grant_o=3'b001 one cycle later, s_ADR_O=0x41000000; s_ACK_I routes to m_ACK_O[0] only.
- Masters 0,1,2 request continuously, each releasing after one ACK. Expect grant order 0,1,2,0 with one IDLE cycle between grants.
- Master 0 runs an 8-word burst with CYC held while master 1 requests. Expect no grant change until 8 ACKs complete and CYC drops; then grant_o=3'b010.
- Master 2 asserts LOCK, drops CYC for 3 cycles, then reasserts, while master 0 requests. Expect grant stays 3'b100 until LOCK falls.
- Reset asserted mid-burst of master 1. Expect s_CYC_O=0 and grant_o=0 after the edge, and master 0 wins first afterwards.
- WB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, slave never ACKs. Expect m_ERR_O[granted] pulse at count 16, return to IDLE, timeout_o=1 until reset.
